// File: rtl/regfile_scoreboard_if.sv
// Bundle of read, issue and write-back signals between decode/issue,
// the write-back stage and the register file with busy scoreboard.
interface regfile_scoreboard_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
);
    // Read ports
    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic              rs1_rdy;
    logic              rs2_rdy;

    // Issue side of the scoreboard
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;
    logic              waw_hazard;

    // Write-back port
    logic              wb_en;
    logic [ADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;

    // Scoreboard occupancy
    logic [ADDR_W:0]   busy_cnt;

    // Pipeline side: decode/issue plus write-back
    modport master (
        output rs1_addr, rs2_addr, issue_valid, issue_rd, wb_en, wb_rd, wb_data,
        input  rs1_data, rs2_data, rs1_rdy, rs2_rdy, waw_hazard, busy_cnt
    );

    // Register file side
    modport slave (
        input  rs1_addr, rs2_addr, issue_valid, issue_rd, wb_en, wb_rd, wb_data,
        output rs1_data, rs2_data, rs1_rdy, rs2_rdy, waw_hazard, busy_cnt
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Integer register file with two combinational read ports, one clocked
// write-back port, optional write-to-read bypass and a per-register busy
// scoreboard used by decode to detect RAW/WAW hazards on in-flight results.
module regfile_scoreboard #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_scoreboard_if.slave  bus
);

    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;
    logic [ADDR_W:0]  busy_cnt_q;

    logic wb_fire;
    logic issue_fire;
    logic set_new;
    logic clr_old;
    logic byp_ok;
    logic byp1_hit;
    logic byp2_hit;

    // Qualify strobes: register 0 is never written and never becomes busy.
    // Forwarding is suppressed while in reset so reads report zero there.
    always_comb begin
        wb_fire    = bus.wb_en && (bus.wb_rd != '0);
        issue_fire = bus.issue_valid && (bus.issue_rd != '0);
        byp_ok     = BYPASS && rst_n && wb_fire;
        byp1_hit   = byp_ok && (bus.wb_rd == bus.rs1_addr);
        byp2_hit   = byp_ok && (bus.wb_rd == bus.rs2_addr);
        // Count moves only on a real 0->1 or 1->0 transition of a busy bit;
        // a same-register issue plus write-back keeps the bit set.
        set_new    = issue_fire && !busy[bus.issue_rd];
        clr_old    = wb_fire && busy[bus.wb_rd] &&
                     !(issue_fire && (bus.issue_rd == bus.wb_rd));
    end

    // Next busy vector: clear on write-back first, then set on issue so a
    // new producer to the same register wins.
    always_comb begin
        // NOTE: every variable written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        busy_next = busy;
        if (wb_fire) begin
            busy_next[bus.wb_rd] = 1'b0;
        end
        if (issue_fire) begin
            busy_next[bus.issue_rd] = 1'b1;
        end
    end

    // Register array write-back; everything clears asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the array is reset deliberately: architectural state must
            // read as zero after reset, which rules out a plain RAM macro.
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_fire) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of block ordering.
            regs[bus.wb_rd] <= bus.wb_data;
        end
    end

    // Busy scoreboard and its incrementally maintained population count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy <= busy_next;
            case ({set_new, clr_old})
                2'b10:   busy_cnt_q <= busy_cnt_q + CNT_ONE;
                2'b01:   busy_cnt_q <= busy_cnt_q - CNT_ONE;
                default: busy_cnt_q <= busy_cnt_q;
            endcase
        end
    end

    // Read port 1: zero for x0, forwarded write-back data on a hit, else array.
    always_comb begin
        if (bus.rs1_addr == '0) begin
            bus.rs1_data = '0;
        end else if (byp1_hit) begin
            bus.rs1_data = bus.wb_data;
        end else begin
            bus.rs1_data = regs[bus.rs1_addr];
        end
        bus.rs1_rdy = (bus.rs1_addr == '0) || !busy[bus.rs1_addr] || byp1_hit;
    end

    // Read port 2: same selection as port 1.
    always_comb begin
        if (bus.rs2_addr == '0) begin
            bus.rs2_data = '0;
        end else if (byp2_hit) begin
            bus.rs2_data = bus.wb_data;
        end else begin
            bus.rs2_data = regs[bus.rs2_addr];
        end
        bus.rs2_rdy = (bus.rs2_addr == '0) || !busy[bus.rs2_addr] || byp2_hit;
    end

    // Hazard flag and occupancy output.
    always_comb begin
        bus.waw_hazard = issue_fire && busy[bus.issue_rd];
        bus.busy_cnt   = busy_cnt_q;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: one instance with bypass, one without, driven identically.
module tb_regfile_scoreboard;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int ADDR_W = 5;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    regfile_scoreboard_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus_b1 ();
    regfile_scoreboard_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus_b0 ();

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .ADDR_W(ADDR_W), .BYPASS(1'b1)) dut_b1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b1.slave)
    );

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .ADDR_W(ADDR_W), .BYPASS(1'b0)) dut_b0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b0.slave)
    );

    // Mirror stimulus onto the no-bypass instance.
    assign bus_b0.rs1_addr    = bus_b1.rs1_addr;
    assign bus_b0.rs2_addr    = bus_b1.rs2_addr;
    assign bus_b0.issue_valid = bus_b1.issue_valid;
    assign bus_b0.issue_rd    = bus_b1.issue_rd;
    assign bus_b0.wb_en       = bus_b1.wb_en;
    assign bus_b0.wb_rd       = bus_b1.wb_rd;
    assign bus_b0.wb_data     = bus_b1.wb_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_b1.issue_valid = 1'b0;
        bus_b1.issue_rd    = '0;
        bus_b1.wb_en       = 1'b0;
        bus_b1.wb_rd       = '0;
        bus_b1.wb_data     = '0;
    endtask

    task automatic check_cnt(input string tag, input int exp);
        check({tag, "_cnt_b1"}, 64'(bus_b1.busy_cnt), 64'(exp));
        check({tag, "_cnt_b0"}, 64'(bus_b0.busy_cnt), 64'(exp));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus_b1.rs1_addr = '0;
        bus_b1.rs2_addr = '0;
        idle_inputs();
        repeat (2) step();

        // Outputs during reset, even with a write-back hitting the read address.
        bus_b1.rs1_addr = 5'd5;
        bus_b1.wb_en    = 1'b1;
        bus_b1.wb_rd    = 5'd5;
        bus_b1.wb_data  = 32'hDEADBEEF;
        #1;
        check("rst_rs1_data_b1", 64'(bus_b1.rs1_data), 64'h0);
        check("rst_rs1_rdy_b1",  64'(bus_b1.rs1_rdy), 64'h1);
        check("rst_rs1_data_b0", 64'(bus_b0.rs1_data), 64'h0);
        check("rst_waw", 64'(bus_b1.waw_hazard), 64'h0);
        check_cnt("rst", 0);
        step();
        idle_inputs();
        rst_n = 1'b1;

        // Read every address on both ports after reset.
        for (int i = 0; i < NREGS; i++) begin
            bus_b1.rs1_addr = ADDR_W'(i);
            bus_b1.rs2_addr = ADDR_W'(NREGS - 1 - i);
            #1;
            check($sformatf("init_rs1_data_%0d", i), 64'(bus_b1.rs1_data), 64'h0);
            check($sformatf("init_rs1_rdy_%0d", i),  64'(bus_b1.rs1_rdy), 64'h1);
            check($sformatf("init_rs2_data_%0d", i), 64'(bus_b0.rs2_data), 64'h0);
            check($sformatf("init_rs2_rdy_%0d", i),  64'(bus_b0.rs2_rdy), 64'h1);
        end
        check_cnt("init", 0);

        // Reset pulse in the middle of a write-back to x5.
        step();
        bus_b1.wb_en   = 1'b1;
        bus_b1.wb_rd   = 5'd5;
        bus_b1.wb_data = 32'hDEADBEEF;
        bus_b1.issue_valid = 1'b1;
        bus_b1.issue_rd    = 5'd6;
        #2;
        rst_n = 1'b0;
        #1;
        check_cnt("midrst", 0);
        step();
        idle_inputs();
        rst_n = 1'b1;
        bus_b1.rs1_addr = 5'd5;
        bus_b1.rs2_addr = 5'd6;
        #1;
        check("midrst_x5_b1", 64'(bus_b1.rs1_data), 64'h0);
        check("midrst_x5_b0", 64'(bus_b0.rs1_data), 64'h0);
        check("midrst_x6_rdy", 64'(bus_b1.rs2_rdy), 64'h1);
        check_cnt("midrst_after", 0);

        // Write-back to x0 is ignored; issue to x0 never marks busy.
        bus_b1.rs1_addr = 5'd0;
        bus_b1.wb_en    = 1'b1;
        bus_b1.wb_rd    = 5'd0;
        bus_b1.wb_data  = 32'hFFFFFFFF;
        #1;
        check("x0_byp_data_b1", 64'(bus_b1.rs1_data), 64'h0);
        check("x0_byp_rdy_b1",  64'(bus_b1.rs1_rdy), 64'h1);
        step();
        idle_inputs();
        #1;
        check("x0_data_b1", 64'(bus_b1.rs1_data), 64'h0);
        check("x0_data_b0", 64'(bus_b0.rs1_data), 64'h0);
        bus_b1.issue_valid = 1'b1;
        bus_b1.issue_rd    = 5'd0;
        #1;
        check("x0_issue_waw", 64'(bus_b1.waw_hazard), 64'h0);
        step();
        idle_inputs();
        check_cnt("x0_issue", 0);
        check("x0_rdy_after_issue", 64'(bus_b1.rs1_rdy), 64'h1);

        // Issue x7, then write it back: bypass vs. no bypass.
        bus_b1.issue_valid = 1'b1;
        bus_b1.issue_rd    = 5'd7;
        step();
        idle_inputs();
        bus_b1.rs1_addr = 5'd7;
        bus_b1.rs2_addr = 5'd7;
        #1;
        check("x7_pend_rdy_b1", 64'(bus_b1.rs1_rdy), 64'h0);
        check("x7_pend_rdy_b0", 64'(bus_b0.rs2_rdy), 64'h0);
        check_cnt("x7_pend", 1);
        bus_b1.wb_en   = 1'b1;
        bus_b1.wb_rd   = 5'd7;
        bus_b1.wb_data = 32'h12345678;
        #1;
        check("x7_wb_data_b1",  64'(bus_b1.rs1_data), 64'h12345678);
        check("x7_wb_rdy_b1",   64'(bus_b1.rs1_rdy), 64'h1);
        check("x7_wb_data2_b1", 64'(bus_b1.rs2_data), 64'h12345678);
        check("x7_wb_rdy2_b1",  64'(bus_b1.rs2_rdy), 64'h1);
        check("x7_wb_data_b0",  64'(bus_b0.rs1_data), 64'h0);
        check("x7_wb_rdy_b0",   64'(bus_b0.rs1_rdy), 64'h0);
        step();
        idle_inputs();
        #1;
        check("x7_after_data_b0", 64'(bus_b0.rs1_data), 64'h12345678);
        check("x7_after_rdy_b0",  64'(bus_b0.rs1_rdy), 64'h1);
        check("x7_after_data_b1", 64'(bus_b1.rs1_data), 64'h12345678);
        check_cnt("x7_after", 0);

        // Same-cycle issue and write-back of x3: data lands, busy set wins.
        bus_b1.issue_valid = 1'b1;
        bus_b1.issue_rd    = 5'd3;
        bus_b1.wb_en       = 1'b1;
        bus_b1.wb_rd       = 5'd3;
        bus_b1.wb_data     = 32'hA5A5A5A5;
        step();
        idle_inputs();
        bus_b1.rs1_addr = 5'd3;
        #1;
        check("x3_data_b1", 64'(bus_b1.rs1_data), 64'hA5A5A5A5);
        check("x3_data_b0", 64'(bus_b0.rs1_data), 64'hA5A5A5A5);
        check("x3_rdy_b1",  64'(bus_b1.rs1_rdy), 64'h0);
        check("x3_rdy_b0",  64'(bus_b0.rs1_rdy), 64'h0);
        check_cnt("x3", 1);
        bus_b1.wb_en   = 1'b1;
        bus_b1.wb_rd   = 5'd3;
        bus_b1.wb_data = 32'h00000033;
        step();
        idle_inputs();
        check_cnt("x3_clear", 0);

        // WAW: second issue to a busy x9.
        bus_b1.issue_valid = 1'b1;
        bus_b1.issue_rd    = 5'd9;
        #1;
        check("x9_first_waw", 64'(bus_b1.waw_hazard), 64'h0);
        step();
        #1;
        check("x9_second_waw_b1", 64'(bus_b1.waw_hazard), 64'h1);
        check("x9_second_waw_b0", 64'(bus_b0.waw_hazard), 64'h1);
        step();
        idle_inputs();
        check_cnt("x9_waw", 1);
        bus_b1.wb_en   = 1'b1;
        bus_b1.wb_rd   = 5'd9;
        bus_b1.wb_data = 32'h00000009;
        step();
        idle_inputs();
        check_cnt("x9_clear", 0);

        // Write-back to a register that is not busy.
        bus_b1.wb_en   = 1'b1;
        bus_b1.wb_rd   = 5'd12;
        bus_b1.wb_data = 32'h0C0C0C0C;
        step();
        idle_inputs();
        bus_b1.rs2_addr = 5'd12;
        #1;
        check("x12_data_b0", 64'(bus_b0.rs2_data), 64'h0C0C0C0C);
        check("x12_rdy_b0",  64'(bus_b0.rs2_rdy), 64'h1);
        check_cnt("x12", 0);

        // Fill the scoreboard: issue x1..x31.
        for (int i = 1; i < NREGS; i++) begin
            bus_b1.issue_valid = 1'b1;
            bus_b1.issue_rd    = ADDR_W'(i);
            step();
        end
        idle_inputs();
        bus_b1.rs2_addr = 5'd31;
        #1;
        check_cnt("full", 31);
        check("full_x31_rdy", 64'(bus_b1.rs2_rdy), 64'h0);

        // Write back x1 while re-issuing x1: count holds at 31.
        bus_b1.issue_valid = 1'b1;
        bus_b1.issue_rd    = 5'd1;
        bus_b1.wb_en       = 1'b1;
        bus_b1.wb_rd       = 5'd1;
        bus_b1.wb_data     = 32'h11111111;
        #1;
        check("full_x1_waw", 64'(bus_b1.waw_hazard), 64'h1);
        step();
        idle_inputs();
        bus_b1.rs1_addr = 5'd1;
        #1;
        check_cnt("full_x1", 31);
        check("full_x1_data", 64'(bus_b1.rs1_data), 64'h11111111);
        check("full_x1_rdy",  64'(bus_b1.rs1_rdy), 64'h0);

        // Write back x2 while issuing x0: count drops to 30.
        bus_b1.issue_valid = 1'b1;
        bus_b1.issue_rd    = 5'd0;
        bus_b1.wb_en       = 1'b1;
        bus_b1.wb_rd       = 5'd2;
        bus_b1.wb_data     = 32'h22222222;
        step();
        idle_inputs();
        bus_b1.rs2_addr = 5'd2;
        #1;
        check_cnt("full_x2", 30);
        check("full_x2_data_b0", 64'(bus_b0.rs2_data), 64'h22222222);
        check("full_x2_rdy_b0",  64'(bus_b0.rs2_rdy), 64'h1);

        // Asynchronous reset mid-cycle clears everything before the next edge.
        bus_b1.rs1_addr = 5'd12;
        #2;
        rst_n = 1'b0;
        #1;
        check_cnt("final_rst", 0);
        check("final_rst_x12", 64'(bus_b1.rs1_data), 64'h0);
        check("final_rst_rdy", 64'(bus_b1.rs2_rdy), 64'h1);
        step();
        rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised integer register file for the pipelined core, replacing the single-cycle register file.
- Two combinational read ports and one clocked write-back port.
- Asynchronous clear of all registers.
- Optional write-to-read bypass.
- Per-register busy scoreboard, so decode can detect RAW/WAW hazards against in-flight destinations.
- Sits between decode/issue and the write-back stage.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (power of two; register 0 hardwired to zero)
ADDR_W, 5, register address width; must equal log2(NREGS)
BYPASS, 1, 1 = same-cycle write-back data forwarded to read ports; 0 = no forwarding

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
rs1_addr  in  ADDR_W  read port 1 address
rs2_addr  in  ADDR_W  read port 2 address
rs1_data  out  XLEN  read port 1 data (combinational)
rs2_data  out  XLEN  read port 2 data (combinational)
rs1_rdy  out  1  1 = rs1 value valid (not pending, or bypassed)
rs2_rdy  out  1  1 = rs2 value valid
issue_valid  in  1  instruction issued this cycle with destination issue_rd
issue_rd  in  ADDR_W  destination of issuing instruction
waw_hazard  out  1  issue_valid && issue_rd != 0 && busy[issue_rd]
wb_en  in  1  write-back strobe
wb_rd  in  ADDR_W  write-back destination
wb_data  in  XLEN  write-back data
busy_cnt  out  ADDR_W+1  number of registers currently busy

Behaviour:
- Reset:
  - rst_n low immediately clears all registers to 0, busy[] to 0 and busy_cnt to 0, independent of clk.
  - Outputs during reset: rsX_data = 0, rsX_rdy = 1, waw_hazard = 0.
  - Reset asserted mid-write: the write is discarded; a register is 0 after reset release.
- Register 0:
  - Reads return 0, rdy = 1 always.
  - wb_en to 0 is ignored.
  - issue_rd = 0 never sets busy[0].
- Write: on rising clk with wb_en = 1 and wb_rd != 0, regs[wb_rd] <= wb_data and busy[wb_rd] <= 0. One-cycle latency to the array.
- Read, latency 0:
  - rsX_data = regs[rsX_addr].
  - When BYPASS = 1 and wb_en && wb_rd == rsX_addr && rsX_addr != 0, rsX_data = wb_data instead.
- Ready:
  - rsX_rdy = (rsX_addr == 0) || !busy[rsX_addr] || (BYPASS && wb_en && wb_rd == rsX_addr).
  - With BYPASS = 0, a pending register becomes ready the cycle after its write-back.
- Scoreboard update at rising clk:
  - issue_valid && issue_rd != 0 sets busy[issue_rd].
  - wb_en && wb_rd != 0 clears busy[wb_rd].
  - Same register issued and written back in one cycle: set wins (new producer pending); data is still written.
- WAW:
  - Issuing to an already busy register is permitted; busy stays 1.
  - The first write-back clears it, so the issuer must stall on waw_hazard.
  - The bench checks that waw_hazard is asserted in that case.
- busy_cnt:
  - Registered; equals popcount of busy[] after each edge.
  - Updated incrementally: +1 on a set of a non-busy register, -1 on a clear of a busy register, net 0 when both occur to different registers.
  - Never exceeds NREGS-1.
- Write-back to a non-busy register: legal, data written, busy unchanged at 0, busy_cnt unchanged.

Test Plan:
- Reset then read all addresses -> data 0, rdy 1, busy_cnt 0; pulse rst_n low mid-write of x5=0xDEADBEEF -> x5 reads 0 after release.
- wb x0=0xFFFFFFFF then read rs1=0 -> 0, rdy 1; issue_rd=0 -> busy_cnt stays 0.
- Issue x7; next cycle rs1=x7 -> rdy 0. wb x7=0x12345678:
  - BYPASS=1: same cycle -> rs1_data 0x12345678, rdy 1.
  - BYPASS=0: rdy 1 only on the following cycle.
- Same-cycle issue x3 and wb x3=0xA5A5A5A5 -> next cycle x3 data 0xA5A5A5A5, busy[3]=1, rs1_rdy 0.
- Issue x9, then issue x9 again -> waw_hazard 1 on second issue; busy_cnt 1.
- Issue x1..x31 one per cycle -> busy_cnt 31. Then, in one cycle, wb x1 and issue x1 -> count 31; then wb x2 + issue x0 -> count 30.
